// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, steers it with predictor + direct-mapped BTB,
// keeps one imem request in flight and buffers returned instructions for decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          BTB_ENTRIES    = 16,
    parameter int          BTB_INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pred_pc,
    input  logic        pred_taken,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_pred_target,
    output logic        id_pred_taken
);

    localparam int TAG_BITS = 32 - BTB_INDEX_BITS - 2;

    typedef logic [BTB_INDEX_BITS-1:0] btb_idx_t;
    typedef logic [TAG_BITS-1:0]       btb_tag_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred_taken;
        logic [31:0] pred_target;
    } fifo_entry_t;

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        btb_valid_q  [BTB_ENTRIES];
    btb_tag_t    btb_tag_q    [BTB_ENTRIES];
    logic [31:0] btb_target_q [BTB_ENTRIES];

    logic        inflight_valid_q, inflight_valid_d;
    logic [31:0] inflight_pc_q;
    logic        inflight_taken_q;
    logic [31:0] inflight_target_q;

    fifo_entry_t fifo_q [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;

    btb_idx_t    lookup_idx, upd_idx;
    btb_tag_t    lookup_tag, upd_tag;
    logic        hit, take, pop, push, issue, btb_we;
    logic [31:0] next_pc;
    logic [2:0]  credit;
    fifo_entry_t head;
    logic        unused_bits;

    // Low address bits never reach any state: fetch is word-granular.
    assign unused_bits = ^{redirect_pc[1:0], upd_pc[1:0]};

    assign lookup_idx = fetch_pc_q[BTB_INDEX_BITS+1:2];
    assign lookup_tag = fetch_pc_q[31:BTB_INDEX_BITS+2];
    assign upd_idx    = upd_pc[BTB_INDEX_BITS+1:2];
    assign upd_tag    = upd_pc[31:BTB_INDEX_BITS+2];

    assign hit     = btb_valid_q[lookup_idx] && (btb_tag_q[lookup_idx] == lookup_tag);
    assign take    = pred_taken && hit;
    assign next_pc = take ? {btb_target_q[lookup_idx][31:2], 2'b00} : fetch_pc_q + 32'd4;

    assign id_valid = (count_q != 2'd0);
    assign pop      = id_valid && id_ready;
    assign push     = inflight_valid_q && !redirect;
    assign btb_we   = upd_valid && upd_taken;

    // Credits count both buffered entries and the one whose data is still on its way.
    assign credit = {1'b0, count_q} + {2'b00, inflight_valid_q} - {2'b00, pop};
    assign issue  = !rst_n && !redirect && (credit < 3'd2);

    assign pred_pc   = fetch_pc_q;
    assign imem_en   = issue;
    assign imem_addr = fetch_pc_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        fetch_pc_d       = fetch_pc_q;
        inflight_valid_d = issue;
        count_d          = count_q;
        rd_ptr_d         = rd_ptr_q;
        wr_ptr_d         = wr_ptr_q;
        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            count_d    = 2'd0;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
        end else begin
            if (issue) begin
                fetch_pc_d = next_pc;
            end
            count_d  = count_q + {1'b0, push} - {1'b0, pop};
            rd_ptr_d = rd_ptr_q ^ pop;
            wr_ptr_d = wr_ptr_q ^ push;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            fetch_pc_q        <= {RESET_PC[31:2], 2'b00};
            inflight_valid_q  <= 1'b0;
            inflight_pc_q     <= 32'd0;
            inflight_taken_q  <= 1'b0;
            inflight_target_q <= 32'd0;
            count_q           <= 2'd0;
            rd_ptr_q          <= 1'b0;
            wr_ptr_q          <= 1'b0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid_q[i] <= 1'b0;
            end
        end else begin
            fetch_pc_q       <= fetch_pc_d;
            inflight_valid_q <= inflight_valid_d;
            count_q          <= count_d;
            rd_ptr_q         <= rd_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            if (issue) begin
                inflight_pc_q     <= fetch_pc_q;
                inflight_taken_q  <= take;
                inflight_target_q <= next_pc;
            end
            if (btb_we) begin
                btb_valid_q[upd_idx] <= 1'b1;
            end
        end
    end

    // NOTE: payload arrays are not reset; only their valid bits / count qualify them.
    always_ff @(posedge clk) begin
        if (btb_we) begin
            btb_tag_q[upd_idx]    <= upd_tag;
            btb_target_q[upd_idx] <= upd_target;
        end
        if (push) begin
            fifo_q[wr_ptr_q] <= '{pc:          inflight_pc_q,
                                  instr:       imem_rdata,
                                  pred_taken:  inflight_taken_q,
                                  pred_target: inflight_target_q};
        end
    end

    // Head fields read as zero when empty so stale payload never leaks to decode.
    assign head           = fifo_q[rd_ptr_q];
    assign id_pc          = id_valid ? head.pc          : 32'd0;
    assign id_instr       = id_valid ? head.instr       : 32'd0;
    assign id_pred_taken  = id_valid ? head.pred_taken  : 1'b0;
    assign id_pred_target = id_valid ? head.pred_target : 32'd0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle vector table, directed multi-cycle sequences,
// and a randomized run scored against a program-order reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [31:0] id_pred_target;
    logic        id_pred_taken;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC      (32'h0000_0000),
        .BTB_ENTRIES   (16),
        .BTB_INDEX_BITS(4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pred_pc       (pred_pc),
        .pred_taken    (pred_taken),
        .imem_en       (imem_en),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_target    (upd_target),
        .upd_taken     (upd_taken),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_pc         (id_pc),
        .id_instr      (id_instr),
        .id_pred_target(id_pred_target),
        .id_pred_taken (id_pred_taken)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Synchronous instruction memory: data for the request appears one cycle later.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= instr_of(imem_addr);
    end

    // Environment predictor: constant 0, constant 1, or a fixed hash of the PC.
    logic [1:0] pred_mode;
    function automatic logic hash_pred(input logic [31:0] pc);
        return ~^pc[6:2];
    endfunction
    always_comb pred_taken = (pred_mode == 2'd2) ? hash_pred(pred_pc) : (pred_mode == 2'd1);

    // Reference: each BTB slot remembers the last taken branch PC mapped to it.
    logic        m_v   [16];
    logic [31:0] m_pc  [16];
    logic [31:0] m_tgt [16];

    function automatic logic m_take(input logic [31:0] pc);
        logic [3:0] i;
        i = pc[5:2];
        return hash_pred(pc) && m_v[i] && (m_pc[i] == pc);
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] pc);
        logic [3:0] i;
        i = pc[5:2];
        return m_take(pc) ? {m_tgt[i][31:2], 2'b00} : pc + 32'd4;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b1;
        repeat (n) step();
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        step();
        redirect    = 1'b0;
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] tgt;
        logic        tk;
    } rec_t;
    rec_t got[$];

    task automatic collect(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (id_valid && id_ready) got.push_back('{id_pc, id_instr, id_pred_target, id_pred_taken});
            step();
        end
    endtask

    // pred_target of entry i must equal the PC delivered after it, taken or not.
    task automatic check_stream(input string name, input logic [31:0] pcs[$], input int taken_at);
        int n;
        n = (got.size() < pcs.size()) ? got.size() : pcs.size();
        check($sformatf("%s_len", name), 32'(n), 32'(pcs.size()));
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_pc%0d", name, i), got[i].pc, pcs[i]);
            check($sformatf("%s_instr%0d", name, i), got[i].instr, instr_of(pcs[i]));
            check($sformatf("%s_tk%0d", name, i), {31'd0, got[i].tk}, {31'd0, i == taken_at});
            if (i + 1 < pcs.size()) check($sformatf("%s_tgt%0d", name, i), got[i].tgt, pcs[i+1]);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        chk_id;
        logic        en;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    // Scoreboard for the randomized phase.
    logic        sb_en = 1'b0;
    logic [31:0] exp_pc;
    logic        acc;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_pc, prev_instr, prev_tgt;
    logic        prev_tk;
    int          occ = 0;
    int          gap = 0;
    int          max_gap = 0;
    int          n_acc = 0;

    always @(negedge clk) begin
        if (sb_en) begin
            acc = id_valid && id_ready;
            if (prev_hold) begin
                check("hold_pc", id_pc, prev_pc);
                check("hold_instr", id_instr, prev_instr);
                check("hold_tgt", id_pred_target, prev_tgt);
                check("hold_tk", {31'd0, id_pred_taken}, {31'd0, prev_tk});
            end
            if (acc) begin
                check("rnd_pc", id_pc, exp_pc);
                check("rnd_instr", id_instr, instr_of(exp_pc));
                check("rnd_tk", {31'd0, id_pred_taken}, {31'd0, m_take(exp_pc)});
                check("rnd_tgt", id_pred_target, m_next(exp_pc));
                exp_pc = m_next(exp_pc);
                n_acc++;
                gap = 0;
            end else begin
                gap++;
                if (gap > max_gap) max_gap = gap;
            end
            occ = redirect ? 0 : occ + int'(imem_en) - int'(acc);
            check("occupancy_le_2", {31'd0, occ <= 2}, 32'd1);
            if (redirect) exp_pc = {redirect_pc[31:2], 2'b00};
            prev_hold  = id_valid && !id_ready && !redirect;
            prev_pc    = id_pc;
            prev_instr = id_instr;
            prev_tgt   = id_pred_target;
            prev_tk    = id_pred_taken;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[$];
        logic [31:0] pcs[$];

        rst_n = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; id_ready = 1'b0;
        upd_valid = 1'b0; upd_pc = 32'd0; upd_target = 32'd0; upd_taken = 1'b0;
        pred_mode = 2'd0;
        for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
        repeat (2) step();

        // Cycle table: reset values, sequential stream, re-reset, backpressure and release.
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h14, 1'b0, 32'h00});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h08, 1'b1, 32'h00});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h08, 1'b1, 32'h00});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h08, 1'b1, 32'h00});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C});

        foreach (tbl[r]) begin
            rst_n    = tbl[r].rst;
            id_ready = tbl[r].rdy;
            @(negedge clk);
            check($sformatf("t%0d_imem_en", r), {31'd0, imem_en}, {31'd0, tbl[r].en});
            check($sformatf("t%0d_imem_addr", r), imem_addr, tbl[r].addr);
            check($sformatf("t%0d_pred_pc", r), pred_pc, tbl[r].addr);
            if (tbl[r].chk_id) begin
                check($sformatf("t%0d_id_valid", r), {31'd0, id_valid}, {31'd0, tbl[r].valid});
                check($sformatf("t%0d_id_pc", r), id_pc, tbl[r].pc);
                check($sformatf("t%0d_id_instr", r), id_instr, tbl[r].valid ? instr_of(tbl[r].pc) : 32'd0);
                if (!tbl[r].valid) begin
                    check($sformatf("t%0d_id_tgt", r), id_pred_target, 32'd0);
                    check($sformatf("t%0d_id_tk", r), {31'd0, id_pred_taken}, 32'd0);
                end
            end
            step();
        end

        // BTB train: taken branch at 0x10 -> 0x40, predictor says taken.
        do_reset(2);
        pred_mode = 2'd1; id_ready = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h10; upd_target = 32'h40; upd_taken = 1'b1;
        got.delete();
        collect(1);
        upd_valid = 1'b0;
        collect(11);
        pcs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h40, 32'h44};
        check_stream("btb_taken", pcs, 4);

        // Same trained entry, predictor says not taken.
        pred_mode = 2'd0;
        do_redirect(32'h0);
        got.delete();
        collect(10);
        pcs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14};
        check_stream("btb_nottaken", pcs, -1);

        // 0x50 shares the 0x10 index but not its tag.
        pred_mode = 2'd1;
        do_redirect(32'h48);
        got.delete();
        collect(8);
        pcs = '{32'h48, 32'h4C, 32'h50, 32'h54};
        check_stream("tag_alias", pcs, -1);

        // Redirect with one buffered entry and one in flight; in-flight data must drop.
        pred_mode = 2'd0; id_ready = 1'b0;
        do_redirect(32'h200);
        step();
        step();
        redirect = 1'b1; redirect_pc = 32'h103;
        @(negedge clk);
        check("rd_busy_valid", {31'd0, id_valid}, 32'd1);
        check("rd_busy_pc", id_pc, 32'h200);
        check("rd_cycle_no_issue", {31'd0, imem_en}, 32'd0);
        step();
        redirect = 1'b0;
        @(negedge clk);
        check("rd_r1_valid", {31'd0, id_valid}, 32'd0);
        check("rd_r1_en", {31'd0, imem_en}, 32'd1);
        check("rd_r1_addr", imem_addr, 32'h100);
        step();
        @(negedge clk);
        check("rd_r2_valid", {31'd0, id_valid}, 32'd0);
        step();
        id_ready = 1'b1;
        @(negedge clk);
        check("rd_r3_valid", {31'd0, id_valid}, 32'd1);
        check("rd_r3_pc", id_pc, 32'h100);
        step();
        got.delete();
        collect(6);
        pcs = '{32'h104, 32'h108, 32'h10C};
        check_stream("rd_after", pcs, -1);

        // Reset mid-operation: buffer full, BTB steering fetch to 0x40 beforehand.
        pred_mode = 2'd1; id_ready = 1'b0;
        do_redirect(32'h0C);
        repeat (3) step();
        @(negedge clk);
        check("pre_rst_valid", {31'd0, id_valid}, 32'd1);
        check("pre_rst_pc", id_pc, 32'h0C);
        check("pre_rst_pred_pc", pred_pc, 32'h40);
        step();
        do_reset(1);
        id_ready = 1'b1;
        @(negedge clk);
        check("post_rst_valid", {31'd0, id_valid}, 32'd0);
        check("post_rst_pred_pc", pred_pc, 32'h0);
        check("post_rst_en", {31'd0, imem_en}, 32'd1);
        got.delete();
        collect(10);
        pcs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14};
        check_stream("post_rst", pcs, -1);

        // Randomized phase: train a small BTB, then random ready and redirects.
        do_reset(2);
        pred_mode = 2'd2; id_ready = 1'b1;
        begin
            logic [31:0] tp[$];
            logic [31:0] tt[$];
            logic        tk[$];
            tp = '{32'h10, 32'h30, 32'h50, 32'h60, 32'h7C, 32'h48};
            tt = '{32'h40, 32'h80, 32'h60, 32'hFFFF_FFF8, 32'h103, 32'h20};
            tk = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
            foreach (tp[k]) begin
                upd_valid = 1'b1; upd_pc = tp[k]; upd_target = tt[k]; upd_taken = tk[k];
                if (tk[k]) begin
                    m_v[tp[k][5:2]]   = 1'b1;
                    m_pc[tp[k][5:2]]  = tp[k];
                    m_tgt[tp[k][5:2]] = tt[k];
                end
                step();
            end
            upd_valid = 1'b0;
        end
        id_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h0;
        sb_en = 1'b1;
        step();
        for (int i = 0; i < 600; i++) begin
            id_ready = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 6))
                0:       redirect_pc = 32'h0;
                1:       redirect_pc = 32'h40;
                2:       redirect_pc = 32'h4C;
                3:       redirect_pc = 32'hFFFF_FFF0;
                4:       redirect_pc = 32'h58;
                5:       redirect_pc = 32'h100;
                default: redirect_pc = $urandom & 32'h1FC;
            endcase
            redirect_pc = redirect_pc | 32'($urandom_range(0, 3));
            step();
        end
        redirect = 1'b0;
        @(negedge clk);
        sb_en = 1'b0;
        check("rnd_max_gap_le_20", {31'd0, max_gap <= 20}, 32'd1);
        check("rnd_accepts_ge_200", {31'd0, n_acc >= 200}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
